// File: rtl/unified_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter_if
// Bus bundle between the pipeline core, the unified memory arbiter and the
// single-port memory model.
//
// Signals:
//   I port : i_req, i_addr (core -> arb); i_rdata, i_ready (arb -> core)
//   D port : d_req, d_we, d_addr, d_wdata (core -> arb); d_rdata, d_ready
//   Memory : mem_en, mem_we, mem_addr, mem_wdata (arb -> mem); mem_rdata
//   Status : busy (arb -> core)
//
// Handshake: a request is a level. The requester raises *_req with stable
// address/we/wdata and holds all of them until it sees the matching *_ready
// pulse, which is high for exactly one cycle. The request may be dropped or
// changed at the clock edge that ends the ready cycle.
//
// Modports:
//   slave  : arbiter side
//   master : core / memory side (used by the testbench)
// ----------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ready, d_rdata, d_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port memory between the instruction-fetch port (I) and
// the MEM-stage data port (D). Each transaction walks IDLE -> ACCESS -> RESP:
// arbitration and request latching happen in IDLE, the memory is driven for
// WAIT_STATES+1 cycles in ACCESS, and the winner gets a one-cycle ready in
// RESP. D normally wins conflicts; after STARVE_MAX consecutive D wins over a
// pending I request, I is forced to win once (STARVE_MAX=0: D always wins).
//
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous, active-low reset
//   bus         : unified_mem_arbiter_if.slave (I/D ports, memory, busy)
//   o_dbg_state : current FSM state (0=IDLE, 1=ACCESS, 2=RESP)
// ----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  unified_mem_arbiter_if.slave        bus,
  output logic [1:0]                  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_STATES);
  // Memory is word addressed on a byte bus: bits [1:0] are always zero.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  state_t              r_state;
  state_t              w_next_state;
  logic                r_grant_d;   // 1: D owns the transaction, 0: I
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wait;
  logic [SW-1:0]       r_starve;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic                w_any_req;
  logic                w_force_i;
  logic                w_pick_d;

  // Arbitration is only meaningful in IDLE; the latching logic below only
  // consumes w_pick_d there.
  assign w_any_req = bus.i_req | bus.d_req;
  assign w_force_i = (STARVE_MAX != 0) && (r_starve == STARVE_LIM);
  assign w_pick_d  = bus.d_req & ~(bus.i_req & w_force_i);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next_state  = r_state;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.i_ready   = 1'b0;
    bus.d_ready   = 1'b0;
    bus.busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (w_any_req) w_next_state = S_ACCESS;
      end
      S_ACCESS: begin
        bus.mem_en = 1'b1;
        bus.mem_we = r_grant_d & r_we;
        if (r_wait == 4'd0) w_next_state = S_RESP;
      end
      S_RESP: begin
        bus.i_ready  = ~r_grant_d;
        bus.d_ready  = r_grant_d;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Transaction latch, wait counter, starvation counter and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant_d <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wait    <= 4'd0;
      r_starve  <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_d <= w_pick_d;
            r_wait    <= WAIT_INIT;
            if (w_pick_d) begin
              r_we    <= bus.d_we;
              r_addr  <= bus.d_addr & ALIGN_MASK;
              r_wdata <= bus.d_wdata;
              // Count D wins only while I is actually waiting.
              if (bus.i_req && (r_starve != STARVE_LIM)) begin
                r_starve <= r_starve + SW'(1);
              end
            end else begin
              r_we     <= 1'b0;
              r_addr   <= bus.i_addr & ALIGN_MASK;
              r_starve <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (r_wait == 4'd0) begin
            if (!r_grant_d) begin
              r_i_rdata <= bus.mem_rdata;
            end else if (!r_we) begin
              r_d_rdata <= bus.mem_rdata;
            end
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_unified_mem_arbiter
// Two arbiter instances: dut_a (WAIT_STATES=1, STARVE_MAX=4) and
// dut_b (WAIT_STATES=0, STARVE_MAX=0), each with its own word memory model.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  localparam int WS_A = 1;
  localparam int SM_A = 4;
  localparam int WS_B = 0;
  localparam int SM_B = 0;

  logic clk;
  logic reset;
  logic mem_init_req;
  logic [1:0] a_state;
  logic [1:0] b_state;

  int n_checks;
  int n_fail;

  logic [32:0] exp_q[$];     // {is_i, expected rdata}
  logic [31:0] last_d_exp;
  logic [31:0] last_i_exp;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_if ();

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS_A), .STARVE_MAX(SM_A)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave), .o_dbg_state(a_state)
  );

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS_B), .STARVE_MAX(SM_B)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave), .o_dbg_state(b_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory models ----------------
  function automatic logic [31:0] init_word(input int i);
    if (i == 0)  return 32'h0050_0113;
    if (i == 25) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | 32'(i);
  endfunction

  assign a_if.mem_rdata = mem_a[a_if.mem_addr[7:2]];
  assign b_if.mem_rdata = mem_b[b_if.mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init_req) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= init_word(i);
    end else if (a_if.mem_en && a_if.mem_we) begin
      mem_a[a_if.mem_addr[7:2]] <= a_if.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (mem_init_req) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= init_word(i);
    end else if (b_if.mem_en && b_if.mem_we) begin
      mem_b[b_if.mem_addr[7:2]] <= b_if.mem_wdata;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for dut_a: every ready pops one expected completion.
  always @(negedge clk) begin
    if (reset && (a_if.i_ready || a_if.d_ready)) begin
      chk("a_one_ready", {a_if.i_ready, a_if.d_ready} == 2'b11, 1'b0);
      if (exp_q.size() == 0) begin
        chk("a_sb_unexpected_ready", 1'b1, 1'b0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("a_sb_port", a_if.i_ready, e[32]);
        chk("a_sb_rdata", a_if.i_ready ? a_if.i_rdata : a_if.d_rdata, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && b_if.i_ready && b_if.d_ready) chk("b_one_ready", 1'b1, 1'b0);
  end

  // ---------------- drivers ----------------
  task automatic run_txn(input logic is_d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data);
    int k;
    int en_cnt;
    int we_cnt;
    logic done;
    logic got_addr;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    @(negedge clk);
    if (is_d) begin
      a_if.d_req = 1'b1; a_if.d_we = we; a_if.d_addr = addr; a_if.d_wdata = wdata;
    end else begin
      a_if.i_req = 1'b1; a_if.i_addr = addr;
    end
    if (is_d && we) begin
      exp_q.push_back({1'b0, last_d_exp});
    end else begin
      exp_q.push_back({~is_d, exp_data});
      if (is_d) last_d_exp = exp_data;
      else      last_i_exp = exp_data;
    end
    k = 0; en_cnt = 0; we_cnt = 0; done = 1'b0; got_addr = 1'b0;
    seen_addr = 32'hFFFF_FFFF; seen_wdata = 32'hFFFF_FFFF;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (a_if.mem_en) begin
        en_cnt++;
        if (!got_addr) begin
          got_addr = 1'b1; seen_addr = a_if.mem_addr; seen_wdata = a_if.mem_wdata;
        end
      end
      if (a_if.mem_we) we_cnt++;
      if (is_d ? a_if.d_ready : a_if.i_ready) done = 1'b1;
    end
    chk("a_latency", k, WS_A + 2);
    chk("a_mem_en_cycles", en_cnt, WS_A + 1);
    chk("a_mem_we_cycles", we_cnt, (is_d && we) ? WS_A + 1 : 0);
    chk("a_mem_addr", seen_addr, addr & 32'hFFFF_FFFC);
    if (is_d && we) chk("a_mem_wdata", seen_wdata, wdata);
    // Drop during the ready cycle; requests are not sampled in RESP.
    a_if.i_req = 1'b0;
    a_if.d_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int n;
    int n_d;
    int n_i;
    int exp_pos;
    logic [31:0] rv;
    int word;

    n_checks = 0; n_fail = 0;
    last_d_exp = 32'h0; last_i_exp = 32'h0;
    a_if.i_req = 0; a_if.i_addr = 0; a_if.d_req = 0; a_if.d_we = 0;
    a_if.d_addr = 0; a_if.d_wdata = 0;
    b_if.i_req = 0; b_if.i_addr = 0; b_if.d_req = 0; b_if.d_we = 0;
    b_if.d_addr = 0; b_if.d_wdata = 0;
    mem_init_req = 1'b1;
    reset = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 32'd0,   32'h0,         32'h0050_0113};
    vecs[1] = '{1'b1, 1'b1, 32'd100, 32'd25,        32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'd100, 32'h0,         32'd25};
    vecs[3] = '{1'b1, 1'b0, 32'd98,  32'h0,         32'hA500_0018};
    vecs[4] = '{1'b0, 1'b0, 32'd7,   32'h0,         32'hA500_0001};
    vecs[5] = '{1'b1, 1'b1, 32'd35,  32'hCAFE_F00D, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'd32,  32'h0,         32'hCAFE_F00D};
    vecs[7] = '{1'b1, 1'b0, 32'd4,   32'h0,         32'hA500_0001};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_mem_en", a_if.mem_en, 1'b0);
    chk("rst_mem_addr", a_if.mem_addr, 32'h0);
    chk("rst_i_rdata", a_if.i_rdata, 32'h0);
    chk("rst_d_rdata", a_if.d_rdata, 32'h0);
    chk("rst_state", a_state, 2'd0);
    mem_init_req = 1'b0;
    reset = 1'b1;

    // Reset in the first ACCESS cycle of a D write to 100
    @(negedge clk);
    a_if.d_req = 1'b1; a_if.d_we = 1'b1; a_if.d_addr = 32'd100; a_if.d_wdata = 32'd25;
    @(negedge clk);
    chk("pre_rst_mem_we", a_if.mem_we, 1'b1);
    chk("pre_rst_mem_addr", a_if.mem_addr, 32'd100);
    reset = 1'b0;
    #1;
    chk("async_mem_en", a_if.mem_en, 1'b0);
    chk("async_mem_we", a_if.mem_we, 1'b0);
    chk("async_busy", a_if.busy, 1'b0);
    chk("async_mem_addr", a_if.mem_addr, 32'h0);
    chk("async_mem_wdata", a_if.mem_wdata, 32'h0);
    chk("async_d_ready", a_if.d_ready, 1'b0);
    @(negedge clk);
    a_if.d_req = 1'b0; a_if.d_we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_state", a_state, 2'd0);
    chk("post_rst_mem100", mem_a[25], 32'hDEAD_BEEF);

    // Table-driven transactions on dut_a
    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_data);
    end
    @(negedge clk);
    chk("a_i_rdata_hold", a_if.i_rdata, last_i_exp);
    chk("a_d_rdata_hold", a_if.d_rdata, last_d_exp);

    // Both held on dut_a: expect D,D,D,D,I twice
    @(negedge clk);
    a_if.i_req = 1'b1; a_if.i_addr = 32'd0;
    a_if.d_req = 1'b1; a_if.d_we = 1'b0; a_if.d_addr = 32'd4;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < SM_A; j++) exp_q.push_back({1'b0, 32'hA500_0001});
      exp_q.push_back({1'b1, 32'h0050_0113});
    end
    last_d_exp = 32'hA500_0001; last_i_exp = 32'h0050_0113;
    n = 0; k = 0;
    while (n < 2 * (SM_A + 1) && k < 200) begin
      @(negedge clk);
      k++;
      if (a_if.i_ready || a_if.d_ready) n++;
    end
    a_if.i_req = 1'b0; a_if.d_req = 1'b0;
    chk("a_starve_completions", n, 2 * (SM_A + 1));
    chk("a_starve_cycles", k, 2 * (SM_A + 1) * (WS_A + 3) - 1);

    // Random write-via-D / read-via-I pairs on dut_a
    for (int r = 0; r < 4; r++) begin
      word = $urandom_range(9, 23);
      rv = $urandom;
      run_txn(1'b1, 1'b1, 32'(word * 4 + $urandom_range(0, 3)), rv, 32'h0);
      run_txn(1'b0, 1'b0, 32'(word * 4), 32'h0, rv);
    end
    @(negedge clk);
    chk("a_sb_drained", exp_q.size(), 0);

    // dut_b: strict D priority, WAIT_STATES=0
    @(negedge clk);
    b_if.i_req = 1'b1; b_if.i_addr = 32'd0;
    b_if.d_req = 1'b1; b_if.d_we = 1'b0; b_if.d_addr = 32'd8;
    n_d = 0; n_i = 0; exp_pos = WS_B + 2;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (b_if.i_ready) n_i++;
      if (b_if.d_ready) begin
        n_d++;
        chk("b_d_ready_pos", c, exp_pos);
        chk("b_d_rdata", b_if.d_rdata, 32'hA500_0002);
        exp_pos = exp_pos + WS_B + 3;
      end
    end
    chk("b_d_count", n_d, 4);
    chk("b_i_starved", n_i, 0);
    b_if.d_req = 1'b0;
    k = 0;
    while (!b_if.i_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b_i_latency", k, WS_B + 3);
    chk("b_i_rdata", b_if.i_rdata, 32'h0050_0113);
    b_if.i_req = 1'b0;
    @(negedge clk);
    chk("b_idle", b_state, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
